// File: rtl/tz_rom_arbiter.sv
// Purpose: shares the 32x32 timezone ROM between the LCD (L) and UART (U) readers, 1-4 word bursts.
// Latency: grant and first ROM issue in the request cycle; RVALID/RDATA READ_LATENCY+1 cycles after each issue.
// Backpressure: none on the return path; a requester holds REQ/ADDR/LEN until its GNT pulse.
module tz_rom_arbiter #(
  parameter int READ_LATENCY  = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        L_REQ,
  input  logic [4:0]  L_ADDR,
  input  logic [1:0]  L_LEN,
  output logic        L_GNT,
  output logic        L_RVALID,
  input  logic        U_REQ,
  input  logic [4:0]  U_ADDR,
  input  logic [1:0]  U_LEN,
  output logic        U_GNT,
  output logic        U_RVALID,
  output logic        RLAST,
  output logic [31:0] RDATA,
  output logic        MEM_EN,
  output logic        MEM_REGCE,
  output logic [4:0]  MEM_ADDR,
  input  logic [31:0] MEM_DATA
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 0 = L, 1 = U
  logic [4:0]  addr_q, addr_d;        // next word address of the running burst
  logic [1:0]  cnt_q, cnt_d;          // words still to issue in the running burst
  logic        favor_u_q, favor_u_d;  // round-robin pointer: 1 when U wins the next tie
  logic [4:0]  mem_addr_q;            // last address driven, held while idle

  logic        issue_vld;
  logic        issue_own;
  logic        issue_last;
  logic [4:0]  issue_addr;
  logic        pick_u;
  logic [1:0]  win_len;
  logic        l_gnt;
  logic        u_gnt;

  // Tag pipeline: stage 0 is the current issue, stage READ_LATENCY lines up with MEM_DATA.
  logic [READ_LATENCY:1] vld_q, own_q, last_q;
  logic [READ_LATENCY:0] vld_s, own_s, last_s;

  logic        l_rvalid_q;
  logic        u_rvalid_q;
  logic        rlast_q;
  logic [31:0] rdata_q;

  // Arbitration and burst sequencing: decides this cycle's ROM issue and the next FSM state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    favor_u_d  = favor_u_q;
    issue_vld  = 1'b0;
    issue_own  = owner_q;
    issue_last = 1'b0;
    issue_addr = mem_addr_q;
    pick_u     = 1'b0;
    win_len    = 2'd0;
    l_gnt      = 1'b0;
    u_gnt      = 1'b0;
    // A grant in the reset cycle would be lost with the flushed pipeline, so none is given.
    if (!RESET) begin
      case (state_q)
        IDLE: begin
          if (L_REQ || U_REQ) begin
            if (L_REQ && U_REQ) begin
              pick_u = (PRIORITY_MODE == 0) && favor_u_q;
            end else begin
              pick_u = U_REQ;
            end
            l_gnt      = !pick_u;
            u_gnt      = pick_u;
            favor_u_d  = !pick_u;
            win_len    = pick_u ? U_LEN : L_LEN;
            issue_vld  = 1'b1;
            issue_own  = pick_u;
            issue_addr = pick_u ? U_ADDR : L_ADDR;
            issue_last = (win_len == 2'd0);
            owner_d    = pick_u;
            addr_d     = issue_addr + 5'd1;
            cnt_d      = win_len;
            if (win_len != 2'd0) begin
              state_d = BURST;
            end
          end
        end
        BURST: begin
          issue_vld  = 1'b1;
          issue_own  = owner_q;
          issue_addr = addr_q;
          issue_last = (cnt_q == 2'd1);
          addr_d     = addr_q + 5'd1;
          cnt_d      = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, burst bookkeeping and held ROM address registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= 5'd0;
      cnt_q      <= 2'd0;
      favor_u_q  <= 1'b0;
      mem_addr_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      favor_u_q <= favor_u_d;
      if (issue_vld) begin
        mem_addr_q <= issue_addr;
      end
    end
  end

  assign vld_s  = {vld_q, issue_vld};
  assign own_s  = {own_q, issue_own};
  assign last_s = {last_q, issue_last};

  // Shift the owner/last tags alongside the ROM's internal pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_q  <= '0;
      own_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_s[READ_LATENCY-1:0];
      own_q  <= own_s[READ_LATENCY-1:0];
      last_q <= last_s[READ_LATENCY-1:0];
    end
  end

  // Capture returning ROM words and steer the valid to the owning requester.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      l_rvalid_q <= 1'b0;
      u_rvalid_q <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      l_rvalid_q <= vld_s[READ_LATENCY] & ~own_s[READ_LATENCY];
      u_rvalid_q <= vld_s[READ_LATENCY] &  own_s[READ_LATENCY];
      rlast_q    <= vld_s[READ_LATENCY] &  last_s[READ_LATENCY];
      if (vld_s[READ_LATENCY]) begin
        rdata_q <= MEM_DATA;
      end
    end
  end

  assign L_GNT     = l_gnt;
  assign U_GNT     = u_gnt;
  assign MEM_EN    = issue_vld;
  assign MEM_ADDR  = issue_addr;
  // Output register only needs enabling the cycle before its word is consumed.
  assign MEM_REGCE = vld_s[READ_LATENCY-1];
  assign L_RVALID  = l_rvalid_q;
  assign U_RVALID  = u_rvalid_q;
  assign RLAST     = rlast_q;
  assign RDATA     = rdata_q;

endmodule

// File: tb/tb_tz_rom_arbiter.sv
// Bench for tz_rom_arbiter: instance 0 round-robin, instance 1 fixed priority.
// A queue-based model of the arbiter and ROM predicts every output each cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_tz_rom_arbiter;

  logic        CLK;
  logic        RESET;
  logic        l_req  [2];
  logic [4:0]  l_addr [2];
  logic [1:0]  l_len  [2];
  logic        u_req  [2];
  logic [4:0]  u_addr [2];
  logic [1:0]  u_len  [2];
  logic        l_gnt  [2];
  logic        u_gnt  [2];
  logic        l_rv   [2];
  logic        u_rv   [2];
  logic        rlast  [2];
  logic [31:0] rdata  [2];
  logic        mem_en [2];
  logic        mem_regce [2];
  logic [4:0]  mem_addr [2];
  logic [31:0] mem_data [2];
  logic [4:0]  rom_a  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tz_rom_arbiter #(.READ_LATENCY(2), .PRIORITY_MODE(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .L_REQ(l_req[0]), .L_ADDR(l_addr[0]), .L_LEN(l_len[0]), .L_GNT(l_gnt[0]), .L_RVALID(l_rv[0]),
    .U_REQ(u_req[0]), .U_ADDR(u_addr[0]), .U_LEN(u_len[0]), .U_GNT(u_gnt[0]), .U_RVALID(u_rv[0]),
    .RLAST(rlast[0]), .RDATA(rdata[0]), .MEM_EN(mem_en[0]), .MEM_REGCE(mem_regce[0]),
    .MEM_ADDR(mem_addr[0]), .MEM_DATA(mem_data[0])
  );

  tz_rom_arbiter #(.READ_LATENCY(2), .PRIORITY_MODE(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .L_REQ(l_req[1]), .L_ADDR(l_addr[1]), .L_LEN(l_len[1]), .L_GNT(l_gnt[1]), .L_RVALID(l_rv[1]),
    .U_REQ(u_req[1]), .U_ADDR(u_addr[1]), .U_LEN(u_len[1]), .U_GNT(u_gnt[1]), .U_RVALID(u_rv[1]),
    .RLAST(rlast[1]), .RDATA(rdata[1]), .MEM_EN(mem_en[1]), .MEM_REGCE(mem_regce[1]),
    .MEM_ADDR(mem_addr[1]), .MEM_DATA(mem_data[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [4:0] a);
    if (a == 5'd5) return 32'h55544320;
    return {16'hC0DE, 11'd0, a};
  endfunction

  // ROM with address register (MEM_EN) and output register (MEM_REGCE).
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) rom_a[k] <= mem_addr[k];
      if (mem_regce[k]) mem_data[k] <= rom_word(rom_a[k]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  m_addr [2][4];
  logic        m_own  [2][4];
  logic        m_last [2][4];
  int          m_n [2];
  int          m_i [2];
  logic        m_favor_u [2];
  logic [4:0]  m_last_addr [2];
  logic [31:0] m_rdata [2];
  logic        s_vld   [2][64];
  logic        s_own   [2][64];
  logic        s_last  [2][64];
  logic        s_regce [2][64];
  logic [31:0] s_data  [2][64];

  task automatic step_model(input int k);
    int s, t, len;
    logic pu, eg_l, eg_u;
    logic [4:0] base, a;
    s = cyc % 64;
    if (RESET) begin
      for (int j = 0; j < 64; j++) begin
        s_vld[k][j] = 1'b0; s_own[k][j] = 1'b0; s_last[k][j] = 1'b0;
        s_regce[k][j] = 1'b0; s_data[k][j] = 32'd0;
      end
      m_n[k] = 0; m_i[k] = 0; m_favor_u[k] = 1'b0;
      m_last_addr[k] = 5'd0; m_rdata[k] = 32'd0;
      return;
    end
    chk($sformatf("d%0d MEM_REGCE", k), mem_regce[k], s_regce[k][s]);
    if (s_vld[k][s]) m_rdata[k] = s_data[k][s];
    chk($sformatf("d%0d L_RVALID", k), l_rv[k], s_vld[k][s] & ~s_own[k][s]);
    chk($sformatf("d%0d U_RVALID", k), u_rv[k], s_vld[k][s] & s_own[k][s]);
    chk($sformatf("d%0d RLAST", k), rlast[k], s_vld[k][s] & s_last[k][s]);
    chk($sformatf("d%0d RDATA", k), rdata[k], m_rdata[k]);
    s_vld[k][s] = 1'b0; s_regce[k][s] = 1'b0;
    eg_l = 1'b0; eg_u = 1'b0;
    if (m_i[k] == m_n[k] && (l_req[k] || u_req[k])) begin
      if (l_req[k] && u_req[k]) pu = (k == 1) ? 1'b0 : m_favor_u[k];
      else pu = u_req[k];
      len  = pu ? int'(u_len[k]) + 1 : int'(l_len[k]) + 1;
      base = pu ? u_addr[k] : l_addr[k];
      for (int w = 0; w < len; w++) begin
        m_addr[k][w] = base + 5'(w);
        m_own[k][w]  = pu;
        m_last[k][w] = (w == len - 1);
      end
      m_n[k] = len; m_i[k] = 0;
      m_favor_u[k] = ~pu;
      eg_l = ~pu; eg_u = pu;
    end
    chk($sformatf("d%0d L_GNT", k), l_gnt[k], eg_l);
    chk($sformatf("d%0d U_GNT", k), u_gnt[k], eg_u);
    if (m_i[k] < m_n[k]) begin
      a = m_addr[k][m_i[k]];
      chk($sformatf("d%0d MEM_EN", k), mem_en[k], 1'b1);
      chk($sformatf("d%0d MEM_ADDR", k), mem_addr[k], a);
      s_regce[k][(s + 1) % 64] = 1'b1;
      t = (s + 3) % 64;
      s_vld[k][t]  = 1'b1;
      s_own[k][t]  = m_own[k][m_i[k]];
      s_last[k][t] = m_last[k][m_i[k]];
      s_data[k][t] = rom_word(a);
      m_last_addr[k] = a;
      m_i[k]++;
    end else begin
      chk($sformatf("d%0d MEM_EN idle", k), mem_en[k], 1'b0);
      chk($sformatf("d%0d MEM_ADDR hold", k), mem_addr[k], m_last_addr[k]);
    end
  endtask

  // Compare process: every cycle, both instances against the model.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) step_model(k);
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic look();
    @(negedge CLK); #1;
  endtask

  initial begin
    logic        en_seen;
    logic [4:0]  seq [4];
    logic [3:0]  uvs, rls;
    logic [9:0]  lg, ug, lr, ur;
    int          lgc, rvc;

    RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      l_req[k] = 1'b0; l_addr[k] = 5'd0; l_len[k] = 2'd0;
      u_req[k] = 1'b0; u_addr[k] = 5'd0; u_len[k] = 2'd0;
    end
    repeat (2) tick();
    RESET = 1'b0;

    // Reset state and 20 idle cycles.
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (i == 0) begin
        chk("rst MEM_EN", mem_en[0], 1'b0);
        chk("rst MEM_ADDR", mem_addr[0], 5'd0);
        chk("rst L_RVALID", l_rv[0], 1'b0);
        chk("rst RDATA", rdata[0], 32'd0);
        chk("rst MEM_REGCE", mem_regce[0], 1'b0);
      end
      en_seen = en_seen | mem_en[0] | mem_en[1];
      tick();
    end
    chk("idle MEM_EN 20 cycles", en_seen, 1'b0);

    // L single read of word 5.
    l_req[0] = 1'b1; l_addr[0] = 5'd5; l_len[0] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      look();
      if (i == 0) begin
        chk("single L_GNT", l_gnt[0], 1'b1);
        chk("single MEM_EN", mem_en[0], 1'b1);
        chk("single MEM_ADDR", mem_addr[0], 5'd5);
      end
      if (i == 3) begin
        chk("single L_RVALID", l_rv[0], 1'b1);
        chk("single RLAST", rlast[0], 1'b1);
        chk("single RDATA", rdata[0], 32'h55544320);
      end
      tick();
      if (i == 0) l_req[0] = 1'b0;
    end

    // U 4-word burst wrapping 30,31,0,1.
    u_req[0] = 1'b1; u_addr[0] = 5'd30; u_len[0] = 2'd3;
    for (int i = 0; i < 7; i++) begin
      look();
      if (i == 0) chk("wrap U_GNT", u_gnt[0], 1'b1);
      if (i < 4) seq[i] = mem_addr[0];
      if (i >= 3) begin
        uvs[i-3] = u_rv[0];
        rls[i-3] = rlast[0];
      end
      tick();
      if (i == 0) u_req[0] = 1'b0;
    end
    chk("wrap addr0", seq[0], 5'd30);
    chk("wrap addr1", seq[1], 5'd31);
    chk("wrap addr2", seq[2], 5'd0);
    chk("wrap addr3", seq[3], 5'd1);
    chk("wrap U_RVALID run", uvs, 4'b1111);
    chk("wrap RLAST pattern", rls, 4'b1000);

    // Contention, round-robin; L re-requests right after its grant.
    l_req[0] = 1'b1; l_addr[0] = 5'd2;  l_len[0] = 2'd1;
    u_req[0] = 1'b1; u_addr[0] = 5'd10; u_len[0] = 2'd1;
    lgc = 0;
    for (int i = 0; i < 10; i++) begin
      look();
      lg[i] = l_gnt[0]; ug[i] = u_gnt[0]; lr[i] = l_rv[0]; ur[i] = u_rv[0];
      tick();
      if (lg[i]) begin
        lgc++;
        if (lgc == 2) l_req[0] = 1'b0;
        else l_addr[0] = 5'd12;
      end
      if (ug[i]) u_req[0] = 1'b0;
    end
    chk("rr L_GNT cycles", lg, 10'h011);
    chk("rr U_GNT cycles", ug, 10'h004);
    chk("rr L_RVALID cycles", lr, 10'h198);
    chk("rr U_RVALID cycles", ur, 10'h060);

    // Fresh tie after L was granted last: U first.
    l_req[0] = 1'b1; l_addr[0] = 5'd7; l_len[0] = 2'd0;
    u_req[0] = 1'b1; u_addr[0] = 5'd8; u_len[0] = 2'd0;
    lg = '0; ug = '0; lr = '0; ur = '0;
    for (int i = 0; i < 6; i++) begin
      look();
      lg[i] = l_gnt[0]; ug[i] = u_gnt[0]; lr[i] = l_rv[0]; ur[i] = u_rv[0];
      tick();
      if (lg[i]) l_req[0] = 1'b0;
      if (ug[i]) u_req[0] = 1'b0;
    end
    chk("tie2 L_GNT cycles", lg, 10'h002);
    chk("tie2 U_GNT cycles", ug, 10'h001);
    chk("tie2 L_RVALID cycles", lr, 10'h010);
    chk("tie2 U_RVALID cycles", ur, 10'h008);

    // Fixed priority instance: U starves until L drops.
    l_req[1] = 1'b1; l_addr[1] = 5'd3; l_len[1] = 2'd0;
    u_req[1] = 1'b1; u_addr[1] = 5'd9; u_len[1] = 2'd0;
    lg = '0; ug = '0;
    for (int i = 0; i < 10; i++) begin
      look();
      lg[i] = l_gnt[1]; ug[i] = u_gnt[1];
      tick();
      if (i == 5) l_req[1] = 1'b0;
      if (ug[i]) u_req[1] = 1'b0;
    end
    chk("prio L_GNT cycles", lg, 10'h03F);
    chk("prio U_GNT cycles", ug, 10'h040);

    // Reset during the 2nd issue of a 4-word L burst.
    l_req[0] = 1'b1; l_addr[0] = 5'd20; l_len[0] = 2'd3;
    look();
    chk("rstmid L_GNT", l_gnt[0], 1'b1);
    tick();
    l_req[0] = 1'b0;
    RESET = 1'b1;
    look();
    tick();
    RESET = 1'b0;
    rvc = 0;
    for (int i = 0; i < 8; i++) begin
      look();
      if (l_rv[0]) rvc++;
      tick();
    end
    chk("rstmid no L_RVALID", rvc, 0);

    // First tie after reset goes to L.
    l_req[0] = 1'b1; l_addr[0] = 5'd1; l_len[0] = 2'd0;
    u_req[0] = 1'b1; u_addr[0] = 5'd2; u_len[0] = 2'd0;
    lg = '0; ug = '0;
    for (int i = 0; i < 3; i++) begin
      look();
      lg[i] = l_gnt[0]; ug[i] = u_gnt[0];
      tick();
      if (lg[i]) l_req[0] = 1'b0;
      if (ug[i]) u_req[0] = 1'b0;
    end
    chk("post-rst L_GNT cycles", lg, 10'h001);
    chk("post-rst U_GNT cycles", ug, 10'h002);

    repeat (6) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tz_rom_arbiter.md
Name: tz_rom_arbiter

Overview:
- Shares the single 32x32 timezone-string ROM between two readers: the LCD action sequencer (port L) and the UART message handler (port U).
- Accepts burst read requests of 1-4 consecutive words.
- Drives the ROM enable, output-register enable and address.
- Returns registered read data tagged to the owning requester.
- Sits between the ROM and its two consumers, replacing the direct shared TZ_DATA/MEM_EN/MEM_OUT_EN wiring.

Parameters:
- READ_LATENCY, 2: cycles from a ROM issue cycle to valid MEM_DATA (address register plus output register).
- PRIORITY_MODE, 0: 0 = round-robin between L and U; 1 = fixed priority, L always wins.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- L_REQ  in  1  LCD read request; held until L_GNT.
- L_ADDR  in  5  LCD start word address.
- L_LEN  in  2  LCD burst length minus 1 (0..3 gives 1..4 words).
- L_GNT  out  1  one-cycle pulse: LCD burst accepted.
- L_RVALID  out  1  RDATA holds an LCD word this cycle.
- U_REQ  in  1  UART read request; held until U_GNT.
- U_ADDR  in  5  UART start word address.
- U_LEN  in  2  UART burst length minus 1.
- U_GNT  out  1  one-cycle pulse: UART burst accepted.
- U_RVALID  out  1  RDATA holds a UART word this cycle.
- RLAST  out  1  qualifies the RVALID word as the final word of its burst.
- RDATA  out  32  registered read data, shared by both ports.
- MEM_EN  out  1  ROM enable; high only in issue cycles.
- MEM_REGCE  out  1  ROM output-register enable.
- MEM_ADDR  out  5  ROM address.
- MEM_DATA  in  32  ROM read data.

Behaviour:
- Reset (sync, RESET high at a rising edge):
  - State goes to IDLE; the round-robin pointer favours L.
  - The issue/tag pipeline is flushed; pending words are dropped and never returned.
  - All outputs are 0 the cycle after reset is sampled.
- FSM states: IDLE and BURST.
- IDLE:
  - No request: MEM_EN=0, MEM_ADDR holds its last value.
  - One or more requests: pick a winner, pulse its GNT in this same cycle, assert MEM_EN, drive MEM_ADDR = winner ADDR.
  - Latch owner, ADDR+1 and remaining count = LEN.
  - LEN=0: stay in IDLE, so back-to-back single-word grants are possible every cycle.
  - LEN>0: go to BURST.
- BURST:
  - Each cycle issues the next word: MEM_EN=1, MEM_ADDR = latched address, which then increments mod 32 (31 wraps to 0).
  - Remaining count decrements each cycle.
  - On the last issue, return to IDLE. Arbitration resumes in the following cycle.
  - No GNT is issued during BURST; the other requester waits and holds REQ/ADDR/LEN.
- Arbitration:
  - PRIORITY_MODE=0: if both request, grant the port not granted most recently. The pointer updates only on a grant.
  - PRIORITY_MODE=1: L always wins a tie, so U can starve while L requests continuously.
- Requester rules:
  - REQ/ADDR/LEN must stay stable until GNT.
  - REQ may drop in the GNT cycle.
  - REQ still high in the cycle after GNT is a new request.
  - A REQ dropped before GNT withdraws the request.
- Return path:
  - A tag pipeline of depth READ_LATENCY carries valid, owner and last bits.
  - MEM_REGCE = tag valid at stage READ_LATENCY-1, i.e. asserted only in the cycle before MEM_DATA is needed.
  - RDATA is captured from MEM_DATA; owner RVALID and RLAST are asserted READ_LATENCY+1 cycles after the issue cycle (3 by default).
  - RDATA holds its value when no RVALID is asserted.
  - L_RVALID and U_RVALID are never high together.
- Throughput and latency:
  - Sustained throughput is 1 word per cycle across bursts.
  - A 4-word burst occupies the ROM for exactly 4 issue cycles.
  - Bursts are returned in issue order with no gaps.

Test Plan:
- Reset then idle: all outputs 0; MEM_EN stays 0 for 20 cycles.
- L single read:
  - Stimulus: L_REQ=1, L_ADDR=5, L_LEN=0 at cycle T, ROM word 5 = 0x55544320.
  - Response: L_GNT and MEM_EN at T with MEM_ADDR=5; L_RVALID=1, RLAST=1, RDATA=0x55544320 at T+3.
- U burst wrap:
  - Stimulus: U_ADDR=30, U_LEN=3.
  - Response: MEM_ADDR sequence 30, 31, 0, 1 on consecutive cycles; U_RVALID for 4 consecutive cycles with RLAST on the 4th only.
- Contention, PRIORITY_MODE=0:
  - Stimulus: L and U both request LEN=1 at T.
  - Response: L granted at T; U granted at T+2; U data follows L data with no gap.
  - Repeat with both requesting again: U wins the tie.
- Fixed priority, PRIORITY_MODE=1:
  - Stimulus: L requests continuously with LEN=0 while U requests.
  - Response: U_GNT stays 0 until L_REQ drops; then U is granted in that same cycle.
- Reset mid-burst:
  - Stimulus: RESET asserted during the 2nd issue of a 4-word L burst.
  - Response: no further L_RVALID after reset is sampled; next request after reset is granted normally with L favoured.
